lifo_reader: RTL and testbench

LIFO_READER -- requirements
Module: lifo_reader

---
 rtl/lifo_reader.sv | 189 ++++++++++++++++++
 tb/tb_lifo_reader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_reader.sv
// lifo_reader
// Pops a burst of up to MAX_COUNT entries from an external LIFO and forwards
// them, in pop order (most recently pushed first), on a valid/ready stream.
// A two-entry output buffer absorbs the one-cycle LIFO read latency, so a
// stalled consumer never causes data loss and a ready consumer sees one beat
// per cycle.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle burst request, honoured only while idle
//   pop_count      burst length, sampled when start is honoured
//   busy           high whenever a burst is being processed
//   done           one-cycle pulse at the end of a burst
//   err            burst ended early because the LIFO ran empty
//   lifo_rd_en     pop request to the LIFO
//   lifo_data_rd   LIFO read data, valid the cycle after lifo_rd_en
//   lifo_empty     LIFO empty flag
//   m_data/m_valid/m_ready  output stream
//
// Build option
//   LIFO_READER_EMPTY_ABORT_EN  when defined, an empty LIFO during a burst ends
//   the burst early and flags err; when undefined the burst waits for data and
//   err is always 0.
module lifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_COUNT  = 12,
  localparam int CNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  lifo_rd_en,
  input  logic [DATA_WIDTH-1:0] lifo_data_rd,
  input  logic                  lifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, POP, DRAIN, DONE} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  in_flight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  logic                  xfer;
  logic [1:0]            occ_left;
  logic [1:0]            pending;
  logic                  drain_clear;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign xfer    = m_valid & m_ready;

  // A beat leaving this cycle frees its slot in time for a pop issued now,
  // because that pop's data only lands in the buffer one cycle later. Counting
  // it as already gone is what allows one pop per cycle with m_ready held high.
  assign occ_left = occ - {1'b0, xfer};
  assign pending  = occ_left + {1'b0, in_flight};

  assign lifo_rd_en = (state == POP) && (remaining != CNT_ZERO) &&
                      !lifo_empty && (pending < 2'd2);

  // Looking at the occupancy after this cycle's transfer lets done follow the
  // final beat by a single cycle instead of two.
  assign drain_clear = !in_flight && (occ_left == 2'd0);

`ifdef LIFO_READER_EMPTY_ABORT_EN
  logic err_q;
  logic empty_abort;

  assign empty_abort = (state == POP) && (remaining != CNT_ZERO) && lifo_empty;
  assign err         = err_q;
`else
  assign err = 1'b0;
`endif

  // Burst control: busy and done are registered alongside the state so they
  // come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= CNT_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LIFO_READER_EMPTY_ABORT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef LIFO_READER_EMPTY_ABORT_EN
            err_q <= 1'b0;
`endif
            busy <= 1'b1;
            if (pop_count != CNT_ZERO) begin
              // Requests beyond the supported burst length are clipped.
              remaining <= (pop_count > CNT_MAX) ? CNT_MAX : pop_count;
              state     <= POP;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        POP: begin
`ifdef LIFO_READER_EMPTY_ABORT_EN
          if (empty_abort) begin
            remaining <= CNT_ZERO;
            err_q     <= 1'b1;
            state     <= DRAIN;
          end else
`endif
          if (lifo_rd_en) begin
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_clear) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer: head_q is the oldest entry and drives m_data directly, so it
  // only changes on a transfer or when the buffer was empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
      occ       <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      in_flight <= lifo_rd_en;
      case ({in_flight, xfer})
        2'b10: begin
          if (occ == 2'd0) begin
            head_q <= lifo_data_rd;
          end else begin
            tail_q <= lifo_data_rd;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_q <= tail_q;
            tail_q <= lifo_data_rd;
          end else begin
            head_q <= lifo_data_rd;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_reader.sv
// tb_lifo_reader
// Drives lifo_reader from a behavioural LIFO and compares the output stream
// with a stack model of the pushed data.
module tb_lifo_reader;

  localparam int DW   = 8;
  localparam int MAXC = 12;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] pop_count = '0;
  logic          busy, done, err, lifo_rd_en;
  logic [DW-1:0] lifo_data_rd = '0;
  logic          lifo_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lifo_reader #(.DATA_WIDTH(DW), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pop_count(pop_count),
    .busy(busy), .done(done), .err(err), .lifo_rd_en(lifo_rd_en),
    .lifo_data_rd(lifo_data_rd), .lifo_empty(lifo_empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  // Behavioural LIFO with registered read data
  logic [DW-1:0] stack[$];
  int            depth = 0;
  logic [DW-1:0] push_vals[16];
  int            push_cnt = 0;
  logic          lifo_clear = 1'b0;

  assign lifo_empty = (depth == 0);

  always @(posedge clk) begin
    if (lifo_clear) begin
      stack.delete();
    end else begin
      if (lifo_rd_en && stack.size() > 0) lifo_data_rd <= stack.pop_back();
      for (int i = 0; i < push_cnt; i++) stack.push_back(push_vals[i]);
    end
    depth <= stack.size();
  end

  // Stream monitor
  int            cyc = 0;
  logic [DW-1:0] obs_q[$];
  int            beat_cyc[$];
  int            rd_pulses = 0, done_count = 0, done_cyc = 0, valid_count = 0;
  int            hold_viol = 0, underflow = 0;
  logic          err_at_done = 1'b0;
  logic          prev_valid = 1'b0, prev_ready = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        obs_q.push_back(m_data);
        beat_cyc.push_back(cyc);
      end
      if (m_valid) valid_count <= valid_count + 1;
      if (lifo_rd_en) begin
        rd_pulses <= rd_pulses + 1;
        if (lifo_empty) underflow <= underflow + 1;
      end
      if (done) begin
        done_count  <= done_count + 1;
        done_cyc    <= cyc;
        err_at_done <= err;
      end
      if (prev_valid && !prev_ready && (!m_valid || m_data != prev_data))
        hold_viol <= hold_viol + 1;
      prev_valid <= m_valid;
      prev_ready <= m_ready;
      prev_data  <= m_data;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  // Reference model: the stack as pushed by the bench
  logic [DW-1:0] model[$];
  int            push_stage = 0;

  int            last_c0, last_base;
  int            rd_at5;
  logic          valid_at5;
  logic [DW-1:0] data_at5, last_first_exp;

  typedef struct {
    int pop_count;
    int fill;
    int mode;
    int exp_beats;
    bit exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  function automatic int obsAt(input int idx);
    return (idx < obs_q.size()) ? int'(obs_q[idx]) : -1;
  endfunction

  function automatic int beatCycAt(input int idx);
    return (idx < beat_cyc.size()) ? beat_cyc[idx] : -1;
  endfunction

  task automatic stageVal(input logic [DW-1:0] v);
    push_vals[push_stage] = v;
    push_stage++;
    model.push_back(v);
  endtask

  task automatic commitPush();
    push_cnt = push_stage;
    @(posedge clk); #1;
    push_cnt = 0;
    push_stage = 0;
  endtask

  task automatic flushLifo();
    lifo_clear = 1'b1;
    @(posedge clk); #1;
    lifo_clear = 1'b0;
    model.delete();
    push_stage = 0;
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) stageVal(DW'($urandom_range(0, 255)));
    commitPush();
  endtask

  task automatic checkBeats(input string name, input int base, input logic [DW-1:0] exp_q[$]);
    checkOutput({name, " beats"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput($sformatf("%s beat%0d", name, i), obsAt(base + i), int'(exp_q[i]));
  endtask

  // mode 0: m_ready high; mode 1: random m_ready; mode 2: low for 6 cycles then high
  task automatic applyStimulus(input string name, input int count, input int mode,
                               input int exp_beats, input bit exp_err, input int glitch_k);
    int base, rd0, done0, k;
    logic [DW-1:0] exp_q[$];
    base = obs_q.size();
    rd0 = rd_pulses;
    done0 = done_count;
    for (int i = 0; i < exp_beats; i++) exp_q.push_back(model.pop_back());
    last_first_exp = (exp_beats > 0) ? exp_q[0] : '0;
    last_base = base;
    last_c0 = cyc;
    k = 0;
    while (done_count == done0 && k < 400) begin
      start = (k == 0) || (k == glitch_k);
      pop_count = (k == 0) ? CW'(count) : CW'($urandom_range(1, MAXC));
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (k > 5);
      endcase
      if (mode == 2 && k == 5) begin
        rd_at5 = rd_pulses - rd0;
        data_at5 = m_data;
        valid_at5 = m_valid;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({name, " done"}, done_count - done0, 1);
    checkBeats(name, base, exp_q);
    checkOutput({name, " rd_en"}, rd_pulses - rd0, exp_beats);
    checkOutput({name, " err"}, err_at_done, exp_err);
    checkOutput({name, " idle busy"}, busy, 0);
    checkOutput({name, " hold"}, hold_viol, 0);
    checkOutput({name, " underflow"}, underflow, 0);
  endtask

  initial begin
    int base, done0, valid0;
    logic [DW-1:0] exp_q[$];

    vecs[0] = '{1, 1, 0, 1, 1'b0};
    vecs[1] = '{2, 5, 1, 2, 1'b0};
    vecs[2] = '{12, 12, 0, 12, 1'b0};
    vecs[3] = '{12, 14, 1, 12, 1'b0};
    vecs[4] = '{7, 7, 2, 7, 1'b0};
    vecs[5] = '{5, 9, 1, 5, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst err", err, 0);
    checkOutput("rst rd_en", lifo_rd_en, 0);
    checkOutput("rst m_valid", m_valid, 0);
    checkOutput("rst m_data", m_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three pushed entries come back newest first, back to back
    flushLifo();
    stageVal(8'h11); stageVal(8'h22); stageVal(8'h33);
    commitPush();
    applyStimulus("basic3", 3, 0, 3, 1'b0, -1);
    checkOutput("basic3 first data", obsAt(last_base), 8'h33);
    checkOutput("basic3 last data", obsAt(last_base + 2), 8'h11);
    checkOutput("basic3 first valid", beatCycAt(last_base) - last_c0, 3);
    checkOutput("basic3 back to back", beatCycAt(last_base + 2) - beatCycAt(last_base), 2);
    checkOutput("basic3 done after beat", done_cyc - beatCycAt(last_base + 2), 1);

    // Consumer stalled: only two pops may be outstanding and data is held
    flushLifo();
    fillRandom(6);
    applyStimulus("stall4", 4, 2, 4, 1'b0, -1);
    checkOutput("stall4 rd_en while stalled", rd_at5, 2);
    checkOutput("stall4 valid while stalled", valid_at5, 1);
    checkOutput("stall4 frozen data", data_at5, last_first_exp);

    // Zero-length burst
    flushLifo();
    fillRandom(2);
    valid0 = valid_count;
    applyStimulus("zero", 0, 0, 0, 1'b0, -1);
    checkOutput("zero done timing", done_cyc - last_c0, 1);
    checkOutput("zero m_valid", valid_count - valid0, 0);

    // start during a burst is ignored
    flushLifo();
    fillRandom(6);
    applyStimulus("restart", 3, 0, 3, 1'b0, 2);
    checkOutput("restart done timing", done_cyc - last_c0, 6);
    checkOutput("restart lifo left", depth, 3);

    // LIFO runs dry mid-burst
    flushLifo();
    stageVal(8'h5A); stageVal(8'h6B);
    commitPush();
`ifdef LIFO_READER_EMPTY_ABORT_EN
    applyStimulus("abort", 5, 0, 2, 1'b1, -1);
    checkOutput("abort err held", err, 1);
`else
    base = obs_q.size();
    done0 = done_count;
    exp_q.delete();
    exp_q.push_back(model.pop_back());
    exp_q.push_back(model.pop_back());
    start = 1'b1; pop_count = CW'(5); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("starve beats", obs_q.size() - base, 2);
    checkOutput("starve busy", busy, 1);
    checkOutput("starve no done", done_count - done0, 0);
    stageVal(8'hA1); stageVal(8'hA2); stageVal(8'hA3);
    commitPush();
    for (int i = 0; i < 3; i++) exp_q.push_back(model.pop_back());
    for (int i = 0; i < 40 && done_count == done0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("starve done", done_count - done0, 1);
    checkBeats("starve", base, exp_q);
    checkOutput("starve err", err_at_done, 0);
    repeat (2) @(posedge clk);
    #1;
`endif

    // Reset with one entry buffered and one in flight
    flushLifo();
    fillRandom(4);
    m_ready = 1'b0;
    start = 1'b1; pop_count = CW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst buffered", m_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst done", done, 0);
    checkOutput("midrst err", err, 0);
    checkOutput("midrst rd_en", lifo_rd_en, 0);
    checkOutput("midrst m_valid", m_valid, 0);
    checkOutput("midrst m_data", m_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    valid0 = valid_count;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrst no beats", valid_count - valid0, 0);
    checkOutput("midrst idle", busy, 0);

    // Table of bursts
    for (int v = 0; v < 6; v++) begin
      flushLifo();
      fillRandom(vecs[v].fill);
      applyStimulus($sformatf("vec%0d", v), vecs[v].pop_count, vecs[v].mode,
                    vecs[v].exp_beats, vecs[v].exp_err, -1);
    end

    // Random bursts with a random consumer
    for (int r = 0; r < 20; r++) begin
      int cnt;
      cnt = $urandom_range(0, MAXC);
      flushLifo();
      fillRandom(cnt + $urandom_range(0, 3));
      applyStimulus($sformatf("rand%0d", r), cnt, 1, cnt, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
